// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronizes, debounces and edge-detects the nickel/dime
// sensors, then emits exclusive N / D / reject pulses. Define COIN_ACCEPTOR_COUNT_EN for coin_count.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  output logic       N,
  output logic       D,
  output logic       reject,
  output logic [7:0] coin_count
);

  localparam logic [7:0] DEB_LIM  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HOLD_LIM = 8'(HOLDOFF_CYCLES);

  typedef enum logic {IDLE = 1'b0, HOLDOFF = 1'b1} state_t;

  // Bit 0 is the nickel sensor, bit 1 the dime sensor throughout.
  logic [1:0]      w_raw;
  logic [1:0]      w_ev;
  logic [1:0]      r_s1;
  logic [1:0]      r_s2;
  logic [1:0]      r_deb;
  logic [1:0]      r_deb_d;
  logic [1:0][7:0] r_cnt;
  state_t          r_state;
  logic [7:0]      r_hcnt;
  logic            r_n;
  logic            r_d;
  logic            r_rej;

  assign w_raw = {dime_raw, nickel_raw};
  assign w_ev  = r_deb & ~r_deb_d;

  // Two-flop synchronizer followed by a stability-count debouncer per sensor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1    <= 2'b00;
      r_s2    <= 2'b00;
      r_deb   <= 2'b00;
      r_deb_d <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_deb[i]) begin
          if ((r_cnt[i] + 8'd1) >= DEB_LIM) begin
            r_deb[i] <= r_s2[i];
            r_cnt[i] <= 8'd0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= 8'd0;
        end
      end
    end
  end

  // Accept/reject FSM; rejects during holdoff do not extend it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_hcnt  <= 8'd0;
      r_n     <= 1'b0;
      r_d     <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_n   <= 1'b0;
      r_d   <= 1'b0;
      r_rej <= 1'b0;
      case (r_state)
        IDLE: begin
          r_hcnt <= 8'd0;
          case (w_ev)
            2'b01: begin
              r_n     <= 1'b1;
              r_state <= HOLDOFF;
            end
            2'b10: begin
              r_d     <= 1'b1;
              r_state <= HOLDOFF;
            end
            2'b11: begin
              r_rej   <= 1'b1;
              r_state <= HOLDOFF;
            end
            default: r_state <= IDLE;
          endcase
        end
        HOLDOFF: begin
          r_rej <= |w_ev;
          if ((r_hcnt + 8'd1) >= HOLD_LIM) begin
            r_hcnt  <= 8'd0;
            r_state <= IDLE;
          end else begin
            r_hcnt  <= r_hcnt + 8'd1;
          end
        end
        default: begin
          r_hcnt  <= 8'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign N      = r_n;
  assign D      = r_d;
  assign reject = r_rej;

`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [7:0] r_count;

  // Saturating total of accepted coins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= 8'd0;
    end else if ((r_n | r_d) && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign coin_count = r_count;
`else
  assign coin_count = 8'd0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomized self-checking bench for coin_acceptor against a sample-history reference model.
module tb_coin_acceptor;
  localparam int DEB  = 4;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       nickel_raw = 1'b0;
  logic       dime_raw = 1'b0;
  logic       N;
  logic       D;
  logic       reject;
  logic [7:0] coin_count;

  int n_cmp = 0;
  int n_mis = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rstn(rstn), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
    .N(N), .D(D), .reject(reject), .coin_count(coin_count)
  );

  always #10 clk = ~clk;

  // Reference model: raw samples per edge since reset, debounced levels, pending rising events.
  bit hist_n[$];
  bit hist_d[$];
  bit m_deb[2];
  bit m_ev[2];
  int m_edge;
  int m_last;
  bit e_n, e_d, e_rej;
  int e_cnt;

  function automatic bit samp(int s, int idx);
    if (idx < 0) return 1'b0;
    return (s == 0) ? hist_n[idx] : hist_d[idx];
  endfunction

  task automatic model_reset();
    hist_n.delete();
    hist_d.delete();
    for (int i = 0; i < 2; i++) begin
      m_deb[i] = 1'b0;
      m_ev[i]  = 1'b0;
    end
    m_edge = 0;
    m_last = -1000;
    e_n = 1'b0; e_d = 1'b0; e_rej = 1'b0;
    e_cnt = 0;
  endtask

  task automatic model_edge();
    bit flip;
    if (!rstn) return;
    hist_n.push_back(nickel_raw);
    hist_d.push_back(dime_raw);
    e_n = 1'b0; e_d = 1'b0; e_rej = 1'b0;
    if (m_ev[0] || m_ev[1]) begin
      if (m_edge > m_last + HOLD) begin
        m_last = m_edge;
        if (m_ev[0] && m_ev[1]) e_rej = 1'b1;
        else begin
          e_n = m_ev[0];
          e_d = m_ev[1];
`ifdef COIN_ACCEPTOR_COUNT_EN
          if (e_cnt < 255) e_cnt = e_cnt + 1;
`endif
        end
      end else begin
        e_rej = 1'b1;
      end
    end
    // Level flips once the last DEB synchronized samples all disagree with it.
    for (int i = 0; i < 2; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (samp(i, m_edge - 2 - j) == m_deb[i]) flip = 1'b0;
      if (flip) m_deb[i] = !m_deb[i];
      m_ev[i] = flip && m_deb[i];
    end
    m_edge = m_edge + 1;
  endtask

  task automatic check_val(string tag, int obs, int exp);
    n_cmp = n_cmp + 1;
    if (obs != exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("N", int'(N), int'(e_n));
    check_val("D", int'(D), int'(e_d));
    check_val("reject", int'(reject), int'(e_rej));
    if (!e_n && !e_d) check_val("coin_count", int'(coin_count), e_cnt);
  endtask

  // Drive at a falling edge, model the rising edge, check at the next falling edge.
  task automatic step(bit nr, bit dr);
    nickel_raw = nr;
    dime_raw   = dr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(int cycles);
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (cycles) step(nickel_raw, dime_raw);
    rstn = 1'b1;
  endtask

  task automatic hold(bit nr, bit dr, int cycles);
    repeat (cycles) step(nr, dr);
  endtask

  int n_seen;
  int sel;
  int len;

  initial begin
    model_reset();
    #5;
    check_val("reset_N", int'(N), 0);
    check_val("reset_D", int'(D), 0);
    check_val("reset_reject", int'(reject), 0);
    check_val("reset_count", int'(coin_count), 0);
    @(negedge clk);
    hold(1'b0, 1'b0, 2);
    rstn = 1'b1;
    hold(1'b0, 1'b0, 5);

    // Clean nickel, bounce, simultaneous, holdoff collision, reset mid-debounce.
    hold(1'b1, 1'b0, 8);  hold(1'b0, 1'b0, 10);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b1, 8);  hold(1'b0, 1'b0, 10);
    step(1'b0, 1'b1); hold(1'b1, 1'b1, 7); step(1'b1, 1'b0); hold(1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 2);  do_reset(2); hold(1'b0, 1'b1, 8); hold(1'b0, 1'b0, 10);

    // Randomized mix of coins, glitches, collisions and resets.
    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 5);
      len = $urandom_range(1, 9);
      case (sel)
        0: hold(1'b1, 1'b0, len);
        1: hold(1'b0, 1'b1, len);
        2: hold(1'b1, 1'b1, len);
        3: for (int j = 0; j < 6; j++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        4: begin
          hold(1'b0, 1'b1, $urandom_range(0, 3));
          hold(1'b1, 1'b1, 7);
        end
        default: begin
          hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len);
          do_reset($urandom_range(1, 3));
        end
      endcase
      hold(1'b0, 1'b0, $urandom_range(0, 8));
    end

    // Saturation: 260 well-spaced nickels.
    hold(1'b0, 1'b0, 10);
    n_seen = 0;
    for (int c = 0; c < 260; c++) begin
      for (int j = 0; j < 12; j++) begin
        step(j < 6, 1'b0);
        if (N) n_seen = n_seen + 1;
      end
    end
    hold(1'b0, 1'b0, 4);
    check_val("nickels_seen", n_seen, 260);
`ifdef COIN_ACCEPTOR_COUNT_EN
    check_val("sat_count", int'(coin_count), 255);
`else
    check_val("sat_count", int'(coin_count), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

- Upstream front end of the vending machine controller.
- Turns raw, asynchronous, bouncy coin-slot sensor lines into clean single-cycle `N` (nickel) and `D` (dime) pulses on the `clk` domain, which feed the Moore vending FSM's `N`/`D` inputs directly.
- Synchronizes and debounces each sensor, detects insertion edges, and rejects ambiguous or too-closely-spaced coins.
- Optionally keeps a running count of accepted coins.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before a sensor level change is accepted (legal range 1–255).
- `HOLDOFF_CYCLES`, default 2: cycles after an accepted or rejected coin during which new coin events are refused (legal range 1–255).
- `clk` in 1: system clock; all state updates on rising edge.
- `rstn` in 1: reset; asynchronous and active-low.
- `nickel_raw` in 1: raw nickel sensor; active-high, asynchronous, may bounce.
- `dime_raw` in 1: raw dime sensor; active-high, asynchronous, may bounce.
- `N` out 1: registered one-cycle pulse, one nickel accepted.
- `D` out 1: registered one-cycle pulse, one dime accepted.
- `reject` out 1: registered one-cycle pulse, coin event refused.
- `coin_count` out 8: accepted-coin total, saturating; see Configuration.

## Operation
- **Synchronizer:** per sensor, a two-flop chain (`s1`, `s2`).
- **Debouncer:** per sensor, a debounced level `deb` and a stability counter `cnt`.
  - On each edge where `s2 != deb`, `cnt` increments.
  - When `cnt` reaches `DEBOUNCE_CYCLES`, `deb` takes the value of `s2` and `cnt` clears, both on that same edge.
  - On any edge where `s2 == deb`, `cnt` clears.
- **Event detection:** an event is a rising edge of `deb` (`deb` high, previous `deb` low). Falling edges produce nothing.
- **FSM, states IDLE, HOLDOFF:**
  - IDLE, exactly one event: register `N` or `D` high for one cycle; go to HOLDOFF.
  - IDLE, nickel and dime events in the same cycle: register `reject` high for one cycle; no `N`/`D`; go to HOLDOFF.
  - HOLDOFF: counts `HOLDOFF_CYCLES` cycles, then returns to IDLE. Any event arriving in HOLDOFF pulses `reject` for one cycle and does not restart the holdoff count.
- **Output exclusivity:** `N`, `D` and `reject` are mutually exclusive in every cycle.
- **Counter:** `coin_count` increments by 1 on each `N` or `D` pulse and saturates at 255 (no wrap).

## Timing
- **Reset values:** all flops 0; FSM in IDLE; `N`=`D`=`reject`=0; `coin_count`=0. These hold immediately on `rstn` low, independent of `clk`.
- **Sensor high at reset release:** because `deb` resets to 0, a sensor already high when `rstn` deasserts is counted as a coin once it has been debounced.
- **Latency:**
  - Raw line first sampled high at edge k and held stable: `deb` rises at edge k+1+`DEBOUNCE_CYCLES`.
  - The output pulse rises at edge k+2+`DEBOUNCE_CYCLES` and falls one edge later.
  - With defaults, the pulse rises at k+6.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles produces no `deb` change and no output.
- **Coin spacing:** minimum spacing between two accepted coins is 1+`HOLDOFF_CYCLES` cycles, measured between output pulses.
- **Reset mid-operation:** reset asserted mid-debounce or mid-holdoff clears all state. No pulse is emitted for any coin in progress.

## Configuration
- Macro `COIN_ACCEPTOR_COUNT_EN`.
- **Defined:** the 8-bit saturating counter is built and drives `coin_count` as described above.
- **Undefined:** no counter logic is built and `coin_count` is tied to 8'd0. All other behaviour is identical.

## Test plan
All scenarios use default parameters, `clk` period 20 ns, and `COIN_ACCEPTOR_COUNT_EN` defined unless noted.
- **Clean nickel:** `nickel_raw` high from edge 10 for 8 cycles -> `N` high for exactly the cycle after edge 16; `D`=`reject`=0; `coin_count`=1.
- **Bounce:** `nickel_raw` toggles 1,0,1,1,0 over 5 cycles, then stays low -> no `N`/`D`/`reject`; `cnt` returns to 0.
- **Simultaneous:** `nickel_raw` and `dime_raw` rise on edge 10 and are held for 8 cycles -> `reject` for one cycle after edge 16; no `N`/`D`; `coin_count` unchanged.
- **Holdoff collision:** `dime_raw` rises at edge 10 (`D` at edge 16); `nickel_raw` rises at edge 11 (`deb` rises at 16, arrives in HOLDOFF) -> `reject` at edge 17; `coin_count`=1.
- **Reset mid-debounce:** `dime_raw` high at edge 10; `rstn` low from edge 12 to edge 14 -> all outputs 0 throughout. If `dime_raw` is still held after release, `D` appears 6 edges after the first post-reset sample.
- **Saturation / macro off:** 260 spaced nickels -> `coin_count` stops at 255. Rebuild without the macro -> `coin_count` stays 0 throughout.
